// File: rtl/key_debounce8.sv
// Eight-channel key conditioner: 2-FF synchroniser, stable-time filter, press strobe and registered any_key.
// Define KEY_ACTIVE_LOW_EN for pull-up buttons (key_raw inverted before the synchroniser).

module key_debounce8_lane #(
    parameter int CNT_W      = 16,
    parameter int STABLE_CNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic level,
    output logic level_nxt,
    output logic press
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;

    // The count only runs while the synced input disagrees with the level.
    // It is cleared whenever they agree, so it never passes CNT_MAX.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        if (sync != level) begin
            if (cnt == CNT_MAX) level_nxt = sync;
            else                cnt_nxt   = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= level_nxt & ~level;
        end
    end
endmodule

module key_debounce8 #(
    parameter int CNT_W      = 16,
    parameter int STABLE_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_raw,
    output logic [7:0] key_out,
    output logic [7:0] key_press,
    output logic       any_key
);
    localparam int NUM_LANES = 8;

    logic [NUM_LANES-1:0] k, s1, s2, key_nxt;

`ifdef KEY_ACTIVE_LOW_EN
    assign k = ~key_raw;
`else
    assign k = key_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= k;
            s2 <= s1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            key_debounce8_lane #(
                .CNT_W      (CNT_W),
                .STABLE_CNT (STABLE_CNT)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .sync      (s2[i]),
                .level     (key_out[i]),
                .level_nxt (key_nxt[i]),
                .press     (key_press[i])
            );
        end
    endgenerate

    // Built from the next-state levels so any_key moves on the same edge as key_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) any_key <= 1'b0;
        else     any_key <= |key_nxt;
    end
endmodule
